uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmitter among N_REQ byte producers.
- Each producer offers one byte with a valid/ready handshake.
- The block picks a winner, pulses the transmitter's start with the latched byte, then holds until the transmitter's done pulse.
- Sits between application logic (e.g. debug/status sources) and the single UART transmitter on the board.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- CLKS_PER_BIT, 1, transmitter bit period in clk cycles; sizes the post-reset flush wait.
- TIMEOUT_CYCLES, 4096, watchdog limit in WAIT_DONE (used only with UART_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  bit i: requester i offers a byte.
- req_data  in  8*N_REQ  byte of requester i at [8*i+7:8*i].
- req_ready  out  N_REQ  one-hot accept; byte i taken on an edge where req_valid[i] and req_ready[i] are both high.
- tx_start  out  1  one-cycle start pulse to the transmitter.
- tx_data  out  8  byte to the transmitter; stable from the tx_start cycle until tx_done.
- tx_done  in  1  one-cycle completion pulse from the transmitter.
- busy  out  1  high whenever a byte is in flight or a flush is running.
- grant_id  out  $clog2(N_REQ)  index of the current or last winner.
- tx_err  out  1  sticky timeout flag (0 when the feature is compiled out).

Behaviour:
- Reset (async assert, sync release):
  - state=FLUSH, flush counter=0; tx_start=0, req_ready=0, tx_data=0, busy=1, grant_id=0, tx_err=0.
  - last_grant=N_REQ-1, so requester 0 has first priority.
- States:
  - FLUSH: the transmitter has no reset and may still be sending. Count FLUSH_CYCLES=10*CLKS_PER_BIT+2 cycles, then go IDLE. tx_done is ignored here.
  - IDLE: busy=0. Winner = first i with req_valid[i], searching from last_grant+1 upward and wrapping modulo N_REQ.
    - req_ready is combinational: one-hot at the winner, only in IDLE; 0 when no request.
    - On the accepting edge: latch tx_data=req_data[winner], grant_id=winner, go LAUNCH.
  - LAUNCH: tx_start=1 for exactly this cycle, busy=1; next state WAIT_DONE.
  - WAIT_DONE: tx_start=0. On tx_done: last_grant=grant_id, go IDLE.
- Latency:
  - tx_start is high in the cycle after acceptance.
  - Next acceptance is possible in the cycle after tx_done.
  - Minimum spacing between acceptances is transmitter time + 2 cycles.
- Fairness: a requester holding valid continuously cannot win twice while another requester is valid.
- Boundary conditions:
  - tx_done outside WAIT_DONE is ignored.
  - tx_done coinciding with LAUNCH is ignored (it is a stale pulse).
  - req_valid dropping before acceptance is allowed; arbitration is re-evaluated every IDLE cycle.
  - Reset mid-byte: next state is FLUSH, never IDLE directly.
  - N_REQ not a power of two: wrap at N_REQ-1 to 0; indices >= N_REQ are never granted.
- Outputs tx_start, tx_data, busy and grant_id are decoded from or held in registers; only req_ready is combinational.

Optional Feature:
- Macro UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES with no tx_done: set tx_err (sticky until reset), last_grant=grant_id, go FLUSH.
  - tx_done on the same cycle as expiry wins; no error is flagged.
- Not defined: no counter; tx_err tied to 0; WAIT_DONE waits indefinitely.

Decomposition:
- Package uart_arb_pkg:
  - state enum {FLUSH, IDLE, LAUNCH, WAIT_DONE}, 2 bits.
  - Function computing FLUSH_CYCLES from CLKS_PER_BIT.
  - Grant-index width function.
- Sub-module rr_picker (combinational):
  - Inputs: req vector, last_grant.
  - Outputs: one-hot grant, grant index, any_valid.
  - Reusable by later arbiters.

Test Plan:
- Reset, then no requests: busy=1 for exactly 12 cycles (CLKS_PER_BIT=1), then 0. tx_start stays 0 throughout.
- req_valid=4'b0001, data 0x55:
  - req_ready=4'b0001 for one cycle.
  - Next cycle tx_start=1 and tx_data=0x55.
  - tx_done after 10 cycles -> busy=0 the next cycle.
- All four valid continuously with distinct bytes 0xA0..0xA3:
  - Grants go 0,1,2,3,0; tx_data sequence A0,A1,A2,A3,A0.
  - Exactly one req_ready bit high per grant.
- valid=4'b1010 after last_grant=1 -> grant 3, then 1. A spurious tx_done pulse in IDLE does not change state.
- rst_n asserted in WAIT_DONE -> outputs reset immediately; FLUSH runs before any new req_ready.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, no tx_done: tx_err=1 after 16 WAIT_DONE cycles, FLUSH entered, tx_err still 1 after the next successful byte.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// State encoding, flush-length arithmetic and index-width helper live here
// so that later arbiters can reuse them.
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ST_FLUSH     = 2'd0,
        ST_IDLE      = 2'd1,
        ST_LAUNCH    = 2'd2,
        ST_WAIT_DONE = 2'd3
    } arb_state_e;

    // One UART frame is 10 bit periods; two spare cycles cover the
    // transmitter's own start/stop bookkeeping.
    function automatic int flush_cycles(input int clks_per_bit);
        return 10 * clks_per_bit + 2;
    endfunction

    // Width of an index into n requesters (at least one bit).
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first asserted request
// strictly after last_i, wrapping at N-1 back to 0. Indices >= N are never
// produced, so non-power-of-two N is handled.
module rr_picker #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] last_i,
    output logic [N-1:0] grant_oh_o,
    output logic [W-1:0] grant_idx_o,
    output logic         any_valid_o
);

    int         cand_sum;
    logic [W-1:0] cand;

    // Scan candidates in priority order; the first hit wins.
    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        any_valid_o = 1'b0;
        cand_sum    = 0;
        cand        = '0;
        for (int k = 1; k <= N; k++) begin
            // last_i < N and k <= N, so two conditional subtractions
            // are enough to reduce the sum modulo N.
            cand_sum = int'(last_i) + k;
            if (cand_sum >= N) cand_sum = cand_sum - N;
            if (cand_sum >= N) cand_sum = cand_sum - N;
            cand = cand_sum[W-1:0];
            if (!any_valid_o && req_i[cand]) begin
                any_valid_o      = 1'b1;
                grant_oh_o[cand] = 1'b1;
                grant_idx_o      = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte
// producers. After reset it flushes (the transmitter has no reset and may
// still be sending), then accepts one byte at a time, pulses tx_start and
// waits for tx_done before arbitrating again.
//
// Optional build macro UART_ARB_TIMEOUT_EN: adds a WAIT_DONE watchdog that
// sets the sticky tx_err flag and re-flushes after TIMEOUT_CYCLES cycles
// without tx_done. Without the macro tx_err is tied low and WAIT_DONE
// waits indefinitely.
//
// Handshake: requester i's byte is taken on a rising edge where
// req_valid[i] and req_ready[i] are both high; req_ready is one-hot at the
// round-robin winner and only ever high in IDLE.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int CLKS_PER_BIT   = 1,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_done,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     tx_err
);

    localparam int GW      = idx_width(N_REQ);
    localparam int FLUSH_N = flush_cycles(CLKS_PER_BIT);
    localparam int FCW     = $clog2(FLUSH_N + 1);
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_N - 1);
    localparam logic [GW-1:0]  LAST_INIT  = GW'(N_REQ - 1);

    // Reject out-of-range configurations at elaboration.
    if (N_REQ < 2 || N_REQ > 16 || CLKS_PER_BIT < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_tx_arbiter: parameter out of range");
    end

    arb_state_e     state_q, state_d;
    logic [FCW-1:0] flush_cnt_q, flush_cnt_d;
    logic [GW-1:0]  last_grant_q, last_grant_d;
    logic [GW-1:0]  grant_id_q, grant_id_d;
    logic [7:0]     tx_data_q, tx_data_d;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCW-1:0] TO_LAST = TCW'(TIMEOUT_CYCLES - 1);
    logic [TCW-1:0] to_cnt_q, to_cnt_d;
    logic           tx_err_q, tx_err_d;
`endif

    logic [N_REQ-1:0] pick_oh;
    logic [GW-1:0]    pick_idx;
    logic             pick_any;

    rr_picker #(
        .N (N_REQ),
        .W (GW)
    ) u_picker (
        .req_i       (req_valid),
        .last_i      (last_grant_q),
        .grant_oh_o  (pick_oh),
        .grant_idx_o (pick_idx),
        .any_valid_o (pick_any)
    );

    // State and datapath registers; reset always lands in FLUSH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FLUSH;
            flush_cnt_q  <= '0;
            last_grant_q <= LAST_INIT;
            grant_id_q   <= '0;
            tx_data_q    <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt_q     <= '0;
            tx_err_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            tx_data_q    <= tx_data_d;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
            tx_err_q     <= tx_err_d;
`endif
        end
    end

    // Next-state, flush counter, acceptance latch and completion bookkeeping.
    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = '0;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        tx_data_d    = tx_data_q;
`ifdef UART_ARB_TIMEOUT_EN
        to_cnt_d     = '0;
        tx_err_d     = tx_err_q;
`endif
        case (state_q)
            ST_FLUSH: begin
                // tx_done is deliberately ignored while flushing.
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (pick_any) begin
                    state_d    = ST_LAUNCH;
                    grant_id_d = pick_idx;
                    tx_data_d  = req_data[{pick_idx, 3'b000} +: 8];
                end
            end
            ST_LAUNCH: begin
                // A tx_done here belongs to an earlier frame and is dropped.
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (tx_done) begin
                    last_grant_d = grant_id_q;
                    state_d      = ST_IDLE;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    tx_err_d     = 1'b1;
                    last_grant_d = grant_id_q;
                    state_d      = ST_FLUSH;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d = ST_FLUSH;
            end
        endcase
    end

    // Outputs decoded from state; only req_ready depends on live inputs.
    always_comb begin
        req_ready = '0;
        tx_start  = 1'b0;
        busy      = 1'b1;
        if (state_q == ST_IDLE) begin
            req_ready = pick_oh;
            busy      = 1'b0;
        end
        if (state_q == ST_LAUNCH) begin
            tx_start = 1'b1;
        end
    end

    assign tx_data  = tx_data_q;
    assign grant_id = grant_id_q;

`ifdef UART_ARB_TIMEOUT_EN
    assign tx_err = tx_err_q;
`else
    assign tx_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (N_REQ=4, CLKS_PER_BIT=1).
// The bench plays the transmitter: it answers each tx_start with a tx_done
// pulse after a chosen delay. Watchdog checks run when UART_ARB_TIMEOUT_EN
// is defined for both bench and design.
module tb_uart_tx_arbiter;

    localparam int N_REQ   = 4;
    localparam int FLUSH_N = 12;
    localparam logic [31:0] ALL = 32'hA3A2A1A0;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        busy;
    logic [1:0]  grant_id;
    logic        tx_err;

    int n_tests = 0;
    int n_fail  = 0;
    int ref_last;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        int          delay;
        int          exp_grant;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs[13];

    uart_tx_arbiter #(
        .N_REQ          (4),
        .CLKS_PER_BIT   (1),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .busy      (busy),
        .grant_id  (grant_id),
        .tx_err    (tx_err)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference rule: first valid requester after the previous winner, wrapping.
    function automatic int rr_ref(input logic [3:0] v, input int last);
        for (int k = 1; k <= N_REQ; k++) begin
            if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int idx);
        logic [3:0] r;
        r = '0;
        if (idx >= 0) r[idx] = 1'b1;
        return r;
    endfunction

    // Offer v/d while idle, check the accept, the launch, the hold while the
    // transmitter is busy, then answer with tx_done after 1+delay wait cycles.
    task automatic send_byte(input logic [3:0] v, input logic [31:0] d, input int delay,
                             input int exp_g, input logic [7:0] exp_b, input string tag);
        logic ok;
        req_valid = v;
        req_data  = d;
        #1;
        check({tag, " ready"}, 32'(req_ready), 32'(onehot(exp_g)));
        if (exp_g < 0) begin
            tick();
            check({tag, " stays idle"}, 32'(busy), 32'd0);
            return;
        end
        exp_q.push_back(exp_b);
        tick();
        check({tag, " tx_start"}, 32'(tx_start), 32'd1);
        check({tag, " grant_id"}, 32'(grant_id), 32'(exp_g));
        check({tag, " tx_data"}, 32'(tx_data), 32'(exp_q.pop_front()));
        check({tag, " launch busy/ready"}, {27'd0, busy, req_ready}, {27'd0, 1'b1, 4'b0000});
        ref_last = exp_g;
        tick();
        ok = 1'b1;
        for (int c = 0; c <= delay; c++) begin
            if (tx_start !== 1'b0 || tx_data !== exp_b || busy !== 1'b1 || req_ready !== 4'b0000)
                ok = 1'b0;
            req_valid = 4'($urandom_range(0, 15));
            if (c < delay) tick();
        end
        check({tag, " hold"}, 32'(ok), 32'd1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check({tag, " done->idle"}, 32'(busy), 32'd0);
    endtask

    // Count consecutive cycles with busy high, bounded.
    task automatic count_busy(output int n, output logic start_seen);
        n = 0;
        start_seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (busy !== 1'b1) break;
            if (tx_start !== 1'b0) start_seen = 1'b1;
            n++;
            tick();
        end
    endtask

    initial begin
        int         n;
        int         w;
        logic       seen;
        logic [3:0] v;
        logic [31:0] d;

        vecs[0]  = '{4'b0001, 32'h00000055, 9, 0, 8'h55};
        vecs[1]  = '{4'b1111, ALL,          2, 1, 8'hA1};
        vecs[2]  = '{4'b1111, ALL,          0, 2, 8'hA2};
        vecs[3]  = '{4'b1111, ALL,          1, 3, 8'hA3};
        vecs[4]  = '{4'b1111, ALL,          3, 0, 8'hA0};
        vecs[5]  = '{4'b1111, ALL,          0, 1, 8'hA1};
        vecs[6]  = '{4'b1010, ALL,          2, 3, 8'hA3};
        vecs[7]  = '{4'b1010, ALL,          0, 1, 8'hA1};
        vecs[8]  = '{4'b0100, 32'h00C50000, 1, 2, 8'hC5};
        vecs[9]  = '{4'b0110, 32'h11223344, 0, 1, 8'h33};
        vecs[10] = '{4'b1001, 32'h5A0000A5, 2, 3, 8'h5A};
        vecs[11] = '{4'b0000, ALL,          0, -1, 8'h00};
        vecs[12] = '{4'b1000, 32'hFF000000, 1, 3, 8'hFF};

        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        tx_done   = 1'b0;
        ref_last  = N_REQ - 1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 32'd1);
        check("rst tx_start/ready", {27'd0, tx_start, req_ready}, 32'd0);
        check("rst tx_data", 32'(tx_data), 32'd0);
        check("rst grant_id", 32'(grant_id), 32'd0);
        check("rst tx_err", 32'(tx_err), 32'd0);

        // Flush length after reset release with no requests
        rst_n = 1'b1;
        #1;
        count_busy(n, seen);
        check("flush length", 32'(n), 32'(FLUSH_N));
        check("flush no tx_start", 32'(seen), 32'd0);

        // Table-driven vectors
        for (int i = 0; i < 13; i++) begin
            send_byte(vecs[i].valid, vecs[i].data, vecs[i].delay,
                      vecs[i].exp_grant, vecs[i].exp_byte, $sformatf("vec%0d", i));
            if (i == 6) begin
                // Spurious tx_done while idle must not disturb anything.
                req_valid = '0;
                tx_done = 1'b1;
                tick();
                tx_done = 1'b0;
                check("spurious done idle", {30'd0, busy, tx_start}, 32'd0);
            end
        end

        // Stale tx_done coinciding with LAUNCH is ignored
        req_valid = 4'b0100;
        req_data  = 32'h007E0000;
        #1;
        tick();
        req_valid = '0;
        check("stale tx_start", 32'(tx_start), 32'd1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("stale ignored busy", {30'd0, busy, tx_start}, 32'd2);
        tick();
        check("stale still waiting", 32'(busy), 32'd1);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("stale grant/data", {22'd0, grant_id, tx_data}, {22'd0, 2'd2, 8'h7E});
        check("stale done->idle", 32'(busy), 32'd0);
        ref_last = 2;

        // Reset while waiting for tx_done
        req_valid = 4'b0001;
        req_data  = ALL;
        #1;
        tick();
        req_valid = '0;
        tick();
        tick();
        req_valid = 4'b1111;
        rst_n = 1'b0;
        #1;
        check("midrst busy", 32'(busy), 32'd1);
        check("midrst outputs", {17'd0, tx_start, req_ready, tx_data, grant_id}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        n = 0;
        for (int c = 0; c < 50; c++) begin
            if (req_ready !== 4'b0000) break;
            n++;
            tick();
        end
        check("midrst flush before ready", 32'(n), 32'(FLUSH_N));
        check("midrst first grant", 32'(req_ready), 32'h1);
        ref_last = N_REQ - 1;
        send_byte(4'b1111, ALL, 1, 0, 8'hA0, "post_rst");

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog: no tx_done for 16 WAIT_DONE cycles
        w = rr_ref(4'b0010, ref_last);
        req_valid = 4'b0010;
        req_data  = ALL;
        #1;
        tick();
        req_valid = '0;
        tick();
        repeat (15) tick();
        check("to before expiry", {30'd0, tx_err, busy}, 32'd1);
        tick();
        check("to expired", {30'd0, tx_err, busy}, 32'd3);
        ref_last = w;
        count_busy(n, seen);
        check("to flush length", 32'(n), 32'(FLUSH_N));
        w = rr_ref(4'b0011, ref_last);
        send_byte(4'b0011, ALL, 2, w, ALL[8*w +: 8], "after_to");
        check("tx_err sticky", 32'(tx_err), 32'd1);
`else
        check("tx_err tied low", 32'(tx_err), 32'd0);
`endif

        // Randomized traffic against the reference rule
        for (int i = 0; i < 40; i++) begin
            v = 4'($urandom_range(0, 15));
            d = $urandom;
            w = rr_ref(v, ref_last);
            send_byte(v, d, $urandom_range(0, 6), w, (w < 0) ? 8'h00 : d[8*w +: 8],
                      $sformatf("rand%0d", i));
        end

        check("scoreboard empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
